// File: rtl/synth_pkg.sv
// synth_pkg: shared state codes, sample width and envelope full-scale for the synth datapath.
package synth_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [15:0] ENV_FULL = 16'hFFFF;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;
endpackage

// File: rtl/env_vca.sv
// env_vca: signed sample times unsigned envelope level, registered on the sample strobe.
module env_vca
  import synth_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_sample_en,
  input  logic signed [SAMPLE_W-1:0] i_sig,
  input  logic        [15:0]         i_level,
  output logic signed [SAMPLE_W-1:0] o_sig
);
  logic signed [2*SAMPLE_W:0] w_prod;
  logic signed [SAMPLE_W-1:0] r_sig;
  // level is widened with a zero MSB so it multiplies as a positive signed value
  assign w_prod = i_sig * $signed({1'b0, i_level});
  assign o_sig  = r_sig;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sig <= '0;
    else if (i_sample_en) r_sig <= SAMPLE_W'(w_prod >>> 16);
  end
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR envelope FSM with trig latch, feeding a registered VCA.
// The envelope advances only on sample_en strobes; trig pulses between strobes are latched.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter logic [15:0] ATTACK_STEP   = 16'd64,
  parameter logic [15:0] DECAY_STEP    = 16'd16,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'd40960,
  parameter logic [15:0] RELEASE_STEP  = 16'd8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic                       gate,
  input  logic                       trig,
  input  logic signed [SAMPLE_W-1:0] sig_in,
  output logic signed [SAMPLE_W-1:0] sig_out,
  output logic        [15:0]         level,
  output logic        [2:0]          state,
  output logic                       busy
);
  state_t      r_state, w_eff, w_state_nxt;
  logic [15:0] r_level, w_level_nxt;
  logic        r_gate, r_trig_pend;
  logic        w_trig, w_rise, w_held;
  logic [16:0] w_add, w_dec, w_rel;
  assign w_trig = r_trig_pend | trig;
  assign w_rise = gate & ~r_gate;
  assign w_held = (r_state == S_ATTACK) || (r_state == S_DECAY) || (r_state == S_SUSTAIN);
  assign w_add  = {1'b0, r_level} + {1'b0, ATTACK_STEP};
  assign w_dec  = {1'b0, r_level} - {1'b0, DECAY_STEP};
  assign w_rel  = {1'b0, r_level} - {1'b0, RELEASE_STEP};
  // Events pick the effective state first; that state's arithmetic then applies on the same strobe.
  always_comb begin
    w_eff       = (!gate && w_held) ? S_RELEASE : ((w_rise || (gate && w_trig)) ? S_ATTACK : r_state);
    w_state_nxt = w_eff;
    w_level_nxt = r_level;
    case (w_eff)
      S_IDLE: w_level_nxt = '0;
      S_ATTACK: begin
        w_level_nxt = (w_add >= {1'b0, ENV_FULL}) ? ENV_FULL : w_add[15:0];
        w_state_nxt = (w_add >= {1'b0, ENV_FULL}) ? S_DECAY : S_ATTACK;
      end
      S_DECAY: begin
        w_level_nxt = (w_dec[16] || w_dec[15:0] <= SUSTAIN_LEVEL) ? SUSTAIN_LEVEL : w_dec[15:0];
        w_state_nxt = (w_dec[16] || w_dec[15:0] <= SUSTAIN_LEVEL) ? S_SUSTAIN : S_DECAY;
      end
      S_RELEASE: begin
        w_level_nxt = (w_rel[16] || w_rel[15:0] == '0) ? '0 : w_rel[15:0];
        w_state_nxt = (w_rel[16] || w_rel[15:0] == '0) ? S_IDLE : S_RELEASE;
      end
      default: w_level_nxt = r_level;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_level     <= '0;
      r_gate      <= 1'b0;
      r_trig_pend <= 1'b0;
    end else begin
      r_trig_pend <= sample_en ? 1'b0 : (r_trig_pend | trig);
      if (sample_en) begin
        r_state <= w_state_nxt;
        r_level <= w_level_nxt;
        r_gate  <= gate;
      end
    end
  end
  env_vca u_vca (
    .clk        (clk),
    .rst        (rst),
    .i_sample_en(sample_en),
    .i_sig      (sig_in),
    .i_level    (r_level),
    .o_sig      (sig_out)
  );
  assign level = r_level;
  assign state = r_state;
  assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed envelope scenarios plus random strobes/gates/trigs checked every cycle against an integer model.
module tb_adsr_envelope;
  logic clk = 0, rst, sample_en = 0, gate = 0, trig = 0;
  logic signed [15:0] sig_in = 0, sig_out;
  logic [15:0] level;
  logic [2:0] state;
  logic busy;
  int errors = 0, checks = 0;
  int m_state = 0, m_level = 0, m_sig = 0;
  bit m_gprev = 0, m_pend = 0;

  adsr_envelope #(.ATTACK_STEP(16'd16384), .DECAY_STEP(16'd8192),
                  .SUSTAIN_LEVEL(16'd32768), .RELEASE_STEP(16'd16384)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .gate(gate), .trig(trig),
    .sig_in(sig_in), .sig_out(sig_out), .level(level), .state(state), .busy(busy));

  always #5 clk = ~clk;

  function automatic int vca(int s, int l);
    longint p;
    p = longint'(s) * longint'(l);
    return int'(p >>> 16);
  endfunction

  task automatic cmp(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
    end
  endtask

  // Reference envelope: plain integer arithmetic, one step per strobe.
  always @(posedge clk or posedge rst) begin
    int st, lv;
    if (rst) begin
      m_state <= 0; m_level <= 0; m_sig <= 0; m_gprev <= 0; m_pend <= 0;
    end else if (sample_en) begin
      st = m_state;
      lv = m_level;
      if (!gate && st >= 1 && st <= 3) st = 4;
      else if (gate && (!m_gprev || m_pend || trig)) st = 1;
      if (st == 0) lv = 0;
      else if (st == 1) begin lv += 16384; if (lv >= 65535) begin lv = 65535; st = 2; end end
      else if (st == 2) begin lv -= 8192; if (lv <= 32768) begin lv = 32768; st = 3; end end
      else if (st == 4) begin lv -= 16384; if (lv <= 0) begin lv = 0; st = 0; end end
      m_sig   <= vca(int'(sig_in), m_level);
      m_state <= st;
      m_level <= lv;
      m_gprev <= gate;
      m_pend  <= 0;
    end else if (trig) m_pend <= 1;
  end

  always @(negedge clk) begin
    cmp("state", int'(state), m_state);
    cmp("level", int'(level), m_level);
    cmp("busy", int'(busy), int'(m_state != 0));
    cmp("sig_out", int'(sig_out), m_sig);
  end

  task automatic strobe();
    @(negedge clk) sample_en = 1;
    @(negedge clk) sample_en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic lit(string n, int lv, int st);
    cmp({n, "_level"}, int'(level), lv);
    cmp({n, "_state"}, int'(state), st);
    cmp({n, "_model_level"}, m_level, lv);
    cmp({n, "_model_state"}, m_state, st);
  endtask

  int exp_l[8] = '{16384, 32768, 49152, 65535, 57343, 49151, 40959, 32768};
  int exp_s[8] = '{1, 1, 1, 2, 2, 2, 2, 3};

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    lit("reset", 0, 0);
    cmp("reset_sig_out", int'(sig_out), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("vca_pin_a", vca(16384, 32768), 8192);
    cmp("vca_pin_b", vca(-32768, 65535), -32768);
    cmp("vca_pin_c", vca(-1, 1), -1);
    // attack then decay into sustain
    gate = 1; sig_in = 16384;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) sig_in = -32768;
      strobe();
      lit("ad", exp_l[i], exp_s[i]);
      if (i == 0) cmp("vca_level0", int'(sig_out), 0);
      if (i == 4) cmp("vca_fullscale_neg", int'(sig_out), -32768);
    end
    sig_in = 16384;
    strobe();
    lit("sustain_hold", 32768, 3);
    cmp("vca_half", int'(sig_out), 8192);
    // release to idle
    gate = 0;
    strobe(); lit("rel1", 16384, 4);
    strobe(); lit("rel2", 0, 0);
    cmp("rel_busy", int'(busy), 0);
    // retrigger mid-release
    gate = 1;
    strobe(); strobe(); lit("re_att", 32768, 1);
    gate = 0;
    strobe(); lit("re_rel", 16384, 4);
    @(negedge clk) begin gate = 1; trig = 1; end
    @(negedge clk) trig = 0;
    strobe(); lit("retrig", 32768, 1);
    // gate fall beats a pending trig
    @(negedge clk) begin gate = 0; trig = 1; end
    @(negedge clk) trig = 0;
    strobe(); lit("prio", 16384, 4);
    strobe(); lit("prio_idle", 0, 0);
    // reset mid-decay
    gate = 1; sig_in = 12345;
    repeat (5) strobe();
    lit("pre_rst", 57343, 2);
    @(negedge clk) rst = 1;
    #1;
    cmp("arst_state", int'(state), 0);
    cmp("arst_level", int'(level), 0);
    cmp("arst_sig_out", int'(sig_out), 0);
    @(negedge clk) begin rst = 0; gate = 0; end
    repeat (3) strobe();
    lit("post_rst", 0, 0);
    // random traffic, back-to-back strobes allowed
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      sample_en = ($urandom_range(2) == 0);
      trig = ($urandom_range(19) == 0);
      if ($urandom_range(39) == 0) gate = ~gate;
      sig_in = 16'($urandom);
      rst = ($urandom_range(1999) == 0);
    end
    @(negedge clk) begin sample_en = 0; trig = 0; rst = 0; end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
